// File: rtl/npc_pkg.sv
// Shared NPC core definitions: CSR address map, CSR array indices and the
// operand-read stage state encoding.
package npc_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam logic [11:0] CSR_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_ADDR_MCAUSE  = 12'h342;

    // Positions in the CSR array; the WBU writes using the same indices.
    localparam logic [1:0] CSR_IDX_MEPC    = 2'd0;
    localparam logic [1:0] CSR_IDX_MSTATUS = 2'd1;
    localparam logic [1:0] CSR_IDX_MCAUSE  = 2'd2;
    localparam logic [1:0] CSR_IDX_MTVEC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2
    } opread_state_e;

endpackage

// File: rtl/csr_index_decode.sv
// Maps a 12-bit CSR address onto the 2-bit CSR array index; unmapped
// addresses decode to index 0 with the illegal flag raised.
module csr_index_decode
    import npc_pkg::*;
(
    input  logic [11:0] addr,
    output logic [1:0]  idx,
    output logic        illegal
);

    always_comb begin
        idx     = CSR_IDX_MEPC;
        illegal = 1'b0;
        case (addr)
            CSR_ADDR_MSTATUS: idx = CSR_IDX_MSTATUS;
            CSR_ADDR_MTVEC:   idx = CSR_IDX_MTVEC;
            CSR_ADDR_MEPC:    idx = CSR_IDX_MEPC;
            CSR_ADDR_MCAUSE:  idx = CSR_IDX_MCAUSE;
            default:          illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/opread_unit.sv
// Operand-read stage: accepts one decoded instruction, waits on the GPR busy
// scoreboard, then registers GPR/CSR operands for the EXU.
module opread_unit
    import npc_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_AW-1:0]          in_rs1,
    input  logic [REG_AW-1:0]          in_rs2,
    input  logic [REG_AW-1:0]          in_rd,
    input  logic                       in_rd_wen,
    input  logic                       in_csr_ren,
    input  logic [11:0]                in_csr_addr,
    input  logic [NREG-1:0][XLEN-1:0]  rf_rdata,
    input  logic [3:0][XLEN-1:0]       csr_rdata,
    input  logic                       wb_valid,
    input  logic [REG_AW-1:0]          wb_rd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_rs1_val,
    output logic [XLEN-1:0]            out_rs2_val,
    output logic [XLEN-1:0]            out_csr_val,
    output logic [REG_AW-1:0]          out_rd,
    output logic                       out_rd_wen,
    output logic [1:0]                 out_csr_idx,
    output logic                       out_csr_illegal
);

    opread_state_e state_reg, state_next;

    logic [REG_AW-1:0] rs1_reg, rs2_reg, rd_reg;
    logic              rd_wen_reg, csr_ren_reg;
    logic [11:0]       csr_addr_reg;

    logic [NREG-1:1]   busy_reg;
    logic [NREG-1:0]   busy_vec;

    logic              accept, hazard, read_fire;
    logic [1:0]        dec_idx;
    logic              dec_illegal;
    logic [XLEN-1:0]   rs1_val_next, rs2_val_next, csr_val_next;

    assign in_ready  = (state_reg == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_reg == ST_HOLD);
    assign busy_vec  = {busy_reg, 1'b0};

    assign hazard = ((rs1_reg != '0) && busy_vec[rs1_reg]) ||
                    ((rs2_reg != '0) && busy_vec[rs2_reg]) ||
                    (rd_wen_reg && (rd_reg != '0) && busy_vec[rd_reg]);
    assign read_fire = (state_reg == ST_READ) && !hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)    state_next = ST_READ;
            ST_READ: if (!hazard)   state_next = ST_HOLD;
            ST_HOLD: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            rd_reg       <= '0;
            rd_wen_reg   <= 1'b0;
            csr_ren_reg  <= 1'b0;
            csr_addr_reg <= '0;
        end else if (accept) begin
            rs1_reg      <= in_rs1;
            rs2_reg      <= in_rs2;
            rd_reg       <= in_rd;
            rd_wen_reg   <= in_rd_wen;
            csr_ren_reg  <= in_csr_ren;
            csr_addr_reg <= in_csr_addr;
        end
    end

    csr_index_decode u_csr_dec (
        .addr    (csr_addr_reg),
        .idx     (dec_idx),
        .illegal (dec_illegal)
    );

    // x0 reads as zero no matter what the register array presents.
    assign rs1_val_next = (rs1_reg == '0) ? '0 : rf_rdata[rs1_reg];
    assign rs2_val_next = (rs2_reg == '0) ? '0 : rf_rdata[rs2_reg];
    assign csr_val_next = (csr_ren_reg && !dec_illegal) ? csr_rdata[dec_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_rs1_val     <= '0;
            out_rs2_val     <= '0;
            out_csr_val     <= '0;
            out_rd          <= '0;
            out_rd_wen      <= 1'b0;
            out_csr_idx     <= '0;
            out_csr_illegal <= 1'b0;
        end else if (read_fire) begin
            out_rs1_val     <= rs1_val_next;
            out_rs2_val     <= rs2_val_next;
            out_csr_val     <= csr_val_next;
            out_rd          <= rd_reg;
            out_rd_wen      <= rd_wen_reg;
            out_csr_idx     <= csr_ren_reg ? dec_idx : CSR_IDX_MEPC;
            out_csr_illegal <= csr_ren_reg && dec_illegal;
        end
    end

    // Scoreboard: a set from this stage beats a same-cycle WBU retirement.
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_reg[gi] <= 1'b0;
                end else if (read_fire && rd_wen_reg && (rd_reg == REG_AW'(gi))) begin
                    busy_reg[gi] <= 1'b1;
                end else if (wb_valid && (wb_rd == REG_AW'(gi))) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_opread_unit.sv
// Bench for opread_unit: directed scenarios plus randomized traffic, with a
// scoreboard queue filled by the driver and drained by an output monitor.
module tb_opread_unit;
    import npc_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid, in_ready;
    logic [4:0]                in_rs1, in_rs2, in_rd;
    logic                      in_rd_wen, in_csr_ren;
    logic [11:0]               in_csr_addr;
    logic [NREG-1:0][XLEN-1:0] rf_rdata;
    logic [3:0][XLEN-1:0]      csr_rdata;
    logic                      wb_valid;
    logic [4:0]                wb_rd;
    logic                      out_valid, out_ready;
    logic [XLEN-1:0]           out_rs1_val, out_rs2_val, out_csr_val;
    logic [4:0]                out_rd;
    logic                      out_rd_wen;
    logic [1:0]                out_csr_idx;
    logic                      out_csr_illegal;

    always #5 clk = ~clk;

    opread_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rd_wen(in_rd_wen), .in_csr_ren(in_csr_ren), .in_csr_addr(in_csr_addr),
        .rf_rdata(rf_rdata), .csr_rdata(csr_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_csr_val(out_csr_val),
        .out_rd(out_rd), .out_rd_wen(out_rd_wen),
        .out_csr_idx(out_csr_idx), .out_csr_illegal(out_csr_illegal)
    );

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] csr;
        logic [4:0]  rd;
        logic        wen;
        logic        ren;
        logic [1:0]  idx;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    bit   model_busy [NREG];
    int   ready_mode = 1;   // 0 random, 1 always ready, 2 never ready

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference CSR map written directly from the address table.
    function automatic exp_t predict(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic wen,
                                     input logic ren, input logic [11:0] addr);
        exp_t e;
        int   slot;
        e.rs1 = (rs1 == 0) ? 32'd0 : rf_rdata[rs1];
        e.rs2 = (rs2 == 0) ? 32'd0 : rf_rdata[rs2];
        e.rd  = rd;
        e.wen = wen;
        e.ren = ren;
        slot  = -1;
        if (addr == 12'h341) slot = 0;
        if (addr == 12'h300) slot = 1;
        if (addr == 12'h342) slot = 2;
        if (addr == 12'h305) slot = 3;
        e.illegal = ren && (slot < 0);
        e.idx     = (slot < 0) ? 2'd0 : 2'(slot);
        e.csr     = (ren && slot >= 0) ? csr_rdata[slot] : 32'd0;
        return e;
    endfunction

    function automatic bit model_hazard(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [4:0] rd, input logic wen);
        return (rs1 != 0 && model_busy[rs1]) || (rs2 != 0 && model_busy[rs2]) ||
               (wen && rd != 0 && model_busy[rd]);
    endfunction

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wen, input logic ren, input logic [11:0] addr);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rd_wen = wen; in_csr_ren = ren; in_csr_addr = addr;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] val);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_rd    = rd;
        if (rd != 0) rf_rdata[rd] = val;
        model_busy[rd] = 1'b0;
        @(posedge clk);
        #1 wb_valid = 1'b0;
    endtask

    // Issue, resolve any scoreboard stall by retiring the blocking registers,
    // then check the two-cycle read latency.
    task automatic run_txn(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic wen, input logic ren, input logic [11:0] addr);
        bit hz;
        hz = model_hazard(rs1, rs2, rd, wen);
        issue(rs1, rs2, rd, wen, ren, addr);
        if (hz) begin
            repeat (3) @(negedge clk);
            check("stall_no_output", 32'(out_valid), 32'd0);
            if (rs1 != 0 && model_busy[rs1]) wb(rs1, $urandom);
            if (rs2 != 0 && model_busy[rs2]) wb(rs2, $urandom);
            if (wen && rd != 0 && model_busy[rd]) wb(rd, $urandom);
        end
        exp_q.push_back(predict(rs1, rs2, rd, wen, ren, addr));
        if (wen && rd != 0) model_busy[rd] = 1'b1;
        @(negedge clk);
        check("latency_read_cycle", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: picks out_ready, pops on handshake, checks stability in HOLD.
    initial begin
        exp_t        e;
        bit          pend = 1'b0;
        logic [31:0] p_rs1, p_csr;
        logic [4:0]  p_rd;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
            if (pend && out_valid && !rst) begin
                check("hold_stable_rs1", out_rs1_val, p_rs1);
                check("hold_stable_csr", out_csr_val, p_csr);
                check("hold_stable_rd", 32'(out_rd), 32'(p_rd));
            end
            if (out_valid && out_ready && !rst) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rs1_val", out_rs1_val, e.rs1);
                    check("rs2_val", out_rs2_val, e.rs2);
                    check("csr_val", out_csr_val, e.csr);
                    check("rd", 32'(out_rd), 32'(e.rd));
                    check("rd_wen", 32'(out_rd_wen), 32'(e.wen));
                    check("csr_illegal", 32'(out_csr_illegal), 32'(e.illegal));
                    if (e.ren) check("csr_idx", 32'(out_csr_idx), 32'(e.idx));
                    $display("[TB] out #%0d rd=%0d rs1=%h rs2=%h csr=%h ill=%0d",
                             n_out, out_rd, out_rs1_val, out_rs2_val, out_csr_val, out_csr_illegal);
                end
            end
            pend  = out_valid && !out_ready && !rst;
            p_rs1 = out_rs1_val;
            p_csr = out_csr_val;
            p_rd  = out_rd;
        end
    end

    initial begin
        logic [31:0] snap_rs1, snap_csr;
        logic [11:0] addr_tab [5];
        logic [4:0]  r1, r2, rdv;
        logic        wv, rv;
        logic [11:0] av;

        addr_tab[0] = 12'h300; addr_tab[1] = 12'h305; addr_tab[2] = 12'h341;
        addr_tab[3] = 12'h342; addr_tab[4] = 12'h344;
        rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_rd_wen = 1'b0; in_csr_ren = 1'b0; in_csr_addr = '0;
        wb_valid = 1'b0; wb_rd = '0;
        for (int i = 0; i < NREG; i++) begin
            rf_rdata[i]   = $urandom;
            model_busy[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) csr_rdata[i] = $urandom;

        repeat (3) @(negedge clk);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        check("rst_out_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_rs1", out_rs1_val, 32'd0);
        check("reset_out_csr", out_csr_val, 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);

        // Basic read and busy set on rd=7.
        rf_rdata[5] = 32'h1234; rf_rdata[6] = 32'hABCD;
        run_txn(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 12'h000);
        drain();

        // Stall on busy x7 until the WBU retires it with a new value.
        run_txn(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 12'h000);
        drain();

        // x0 reads zero and a wb to x0 never stalls.
        rf_rdata[0] = 32'hFFFF_FFFF;
        wb(5'd0, 32'h0);
        run_txn(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 12'h000);

        // CSR mapped and unmapped reads.
        csr_rdata[0] = 32'h8000_0010;
        run_txn(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 12'h341);
        run_txn(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 12'h344);
        drain();

        // Set wins over a coincident retirement of the same index.
        issue(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 12'h000);
        exp_q.push_back(predict(5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 12'h000));
        wb_valid = 1'b1; wb_rd = 5'd9;
        model_busy[9] = 1'b1;
        @(posedge clk); #1 wb_valid = 1'b0;
        @(negedge clk);
        check("set_wins_out_valid", 32'(out_valid), 32'd1);
        run_txn(5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 12'h000);
        drain();

        // Backpressure: outputs frozen and in_ready low while out_ready=0.
        ready_mode = 2;
        run_txn(5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 12'h300);
        snap_rs1 = out_rs1_val; snap_csr = out_csr_val;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_rs1_stable", out_rs1_val, snap_rs1);
            check("bp_csr_stable", out_csr_val, snap_csr);
        end
        @(posedge clk); #1 ready_mode = 1;
        @(negedge clk);
        check("bp_release_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        drain();

        // Reset while stalled in READ clears the scoreboard.
        run_txn(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 12'h000);
        drain();
        issue(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 12'h000);
        repeat (2) @(negedge clk);
        check("rst_test_stalled", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1 check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < NREG; i++) model_busy[i] = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
        check("rst_mid_out_rd", 32'(out_rd), 32'd0);
        run_txn(5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 12'h000);
        drain();

        // Randomized traffic with random backpressure and idle retirements.
        ready_mode = 0;
        for (int t = 0; t < 150; t++) begin
            for (int k = 0; k < 3; k++) rf_rdata[$urandom_range(0, 7)] = $urandom;
            csr_rdata[$urandom_range(0, 3)] = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                rdv = 5'($urandom_range(1, 7));
                if (model_busy[rdv]) wb(rdv, $urandom);
            end
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            rdv = 5'($urandom_range(0, 7));
            wv  = 1'($urandom_range(0, 1));
            rv  = 1'($urandom_range(0, 1));
            av  = ($urandom_range(0, 5) == 5) ? 12'($urandom) : addr_tab[$urandom_range(0, 4)];
            run_txn(r1, r2, rdv, wv, rv, av);
        end
        ready_mode = 1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
